noc_credit_rx: RTL and testbench
================================

NOC_CREDIT_RX -- requirements
Module: noc_credit_rx

Purpose: receive-side stage feeding the NoC-to-RV bridge. It accepts credit-based (valid/yummy) NoC flits from the chip, buffers them, and presents them on a valid/ready stream with packet framing.

Interface
REQ-001 Parameter DATA_WIDTH, default 64: flit width, equal to NOC_DATA_WIDTH.
REQ-002 Parameter DEPTH, default 4: buffer entries, equal to the credits granted to the sender; a power of two, >= 2.
REQ-003 Parameter LEN_LSB, default 22: LSB of the payload-length field in a header flit.
REQ-004 Parameter LEN_WIDTH, default 8: width of the payload-length field.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  flit present on in_data this cycle.
REQ-008 in_data  input  DATA_WIDTH  incoming flit.
REQ-009 in_yummy  output  1  one-cycle credit-return pulse, one per freed entry.
REQ-010 out_valid  output  1  buffer head is valid.
REQ-011 out_data  output  DATA_WIDTH  buffer head flit.
REQ-012 out_last  output  1  head flit is the final flit of its packet.
REQ-013 out_ready  input  1  consumer accepts the head this cycle.
REQ-014 overflow  output  1  sticky flag: a flit arrived with no free entry (sender credit violation).

Function
REQ-015 The buffer SHALL be a DEPTH-entry circular FIFO with read/write pointers wrapping modulo DEPTH and an occupancy count of 0..DEPTH.
REQ-016 Enqueue SHALL occur when in_valid=1 and, at cycle start, either count<DEPTH or a dequeue occurs in the same cycle.
REQ-017 When in_valid=1, count==DEPTH and no same-cycle dequeue: the flit is dropped, overflow is set to 1 and held until reset, and FIFO state is unchanged.
REQ-018 Dequeue SHALL occur when out_valid=1 and out_ready=1.
REQ-019 out_valid SHALL equal (count!=0) and out_data SHALL equal the head entry; both are driven from registered state only.
REQ-020 Latency: a flit enqueued at edge N SHALL appear on out_data/out_valid in the cycle following edge N, i.e. 1 cycle of latency with an empty FIFO.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-022 in_yummy SHALL be a registered pulse asserted in the cycle after each dequeue; back-to-back dequeues SHALL give back-to-back pulses, and the total pulse count SHALL equal the total dequeue count.
REQ-023 The framing FSM SHALL have two states, HEAD and BODY, plus a LEN_WIDTH-bit remaining counter rem.
REQ-024 In HEAD, out_last SHALL be 1 iff the length field in_head[LEN_LSB+LEN_WIDTH-1:LEN_LSB] is 0.
REQ-025 On dequeue in HEAD with length 0, the FSM SHALL stay in HEAD.
REQ-026 On dequeue in HEAD with length L>0, the FSM SHALL go to BODY with rem=L.
REQ-027 In BODY, out_last SHALL be 1 iff rem==1.
REQ-028 On dequeue in BODY, rem SHALL decrement; when rem was 1, the FSM SHALL return to HEAD.
REQ-029 out_last SHALL be 0 whenever out_valid=0.
REQ-030 The FSM and rem SHALL change only on dequeue; the payload field of body flits SHALL never be interpreted.
REQ-031 Maximum packet length SHALL be 2^LEN_WIDTH flits (1 header + 255 body at the defaults), with no truncation.

Reset
REQ-032 While reset=1 at an edge: FIFO empty (count=0, pointers=0), FSM=HEAD, rem=0, overflow=0, and the in_yummy register=0; all flits and pending credits are discarded.
REQ-033 After reset, out_valid=0, out_last=0 and in_yummy=0 in the first cycle; out_data is don't-care while out_valid=0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; the first flit after reset SHALL be treated as a header.
REQ-035 An in_valid flit arriving in a cycle where reset=1 SHALL be ignored.

Verification
REQ-036 Single flit, header length 0, out_ready=1 -> out_valid=1 and out_last=1 one cycle later; in_yummy pulses exactly once, on the following cycle.
REQ-037 Packet with header length 3, 4 flits streamed, out_ready=1 -> out_last pattern 0,0,0,1; FSM back in HEAD; 4 in_yummy pulses.
REQ-038 out_ready=0 while 4 flits are sent (DEPTH=4) -> count=4, no in_yummy pulses; a 5th flit sets overflow=1 and is dropped; releasing out_ready yields exactly the first 4 flits in order.
REQ-039 FIFO full with simultaneous in_valid and dequeue -> flit accepted, overflow stays 0, count stays 4.
REQ-040 Reset pulsed after 2 of 5 flits of a length-4 packet -> outputs return to reset values; the next flit, with length 1, is framed as a header and gives out_last pattern 0,1.
REQ-041 Random valid/ready traffic over at least 10000 flits within the credit limit -> output order equals input order, total in_yummy pulses equal total dequeues, overflow=0.

Source files
------------

// File: rtl/noc_credit_rx.sv
// Receive stage for credit-based (valid/yummy) NoC flits: DEPTH-entry FIFO with
// credit return on every dequeue, plus header-length packet framing on the output.
module noc_credit_rx #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int LEN_LSB    = 22,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_yummy,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  yummy_q;
    logic                  overflow_q;
    state_e                state_q;
    logic [LEN_WIDTH-1:0]  rem_q;

    logic                  deq_s, enq_s, full_s, drop_s;
    logic [LEN_WIDTH-1:0]  head_len_s;

    // FIFO handshake decode and next-state pointer/occupancy computation
    always_comb begin
        full_s   = (count_q == CW'(DEPTH));
        deq_s    = out_valid & out_ready;
        enq_s    = in_valid & (~full_s | deq_s);
        drop_s   = in_valid & full_s & ~deq_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (deq_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control state, credit-return pulse and sticky credit-violation flag
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            yummy_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            yummy_q    <= deq_s;
            overflow_q <= overflow_q | drop_s;
        end
    end

    // Storage array; contents are meaningless while the matching slot is not occupied
    always_ff @(posedge clock) begin
        if (enq_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Framing FSM advances only when a flit leaves; body payload is never decoded
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_HEAD;
            rem_q   <= '0;
        end else if (deq_s) begin
            case (state_q)
                ST_HEAD: begin
                    if (head_len_s != LEN_WIDTH'(0)) begin
                        state_q <= ST_BODY;
                        rem_q   <= head_len_s;
                    end else begin
                        state_q <= ST_HEAD;
                    end
                end
                ST_BODY: begin
                    rem_q <= rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_q <= ST_HEAD;
                    end else begin
                        state_q <= ST_BODY;
                    end
                end
                default: begin
                    state_q <= ST_HEAD;
                    rem_q   <= '0;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    // Output view: head entry and framing flag derived purely from registered state
    always_comb begin
        out_valid  = (count_q != CW'(0));
        out_data   = mem_q[rd_ptr_q];
        head_len_s = out_data[LEN_LSB +: LEN_WIDTH];
        out_last   = 1'b0;
        if (!out_valid) begin
            out_last = 1'b0;
        end else begin
            case (state_q)
                ST_HEAD: out_last = (head_len_s == LEN_WIDTH'(0));
                ST_BODY: out_last = (rem_q == LEN_WIDTH'(1));
                default: out_last = 1'b0;
            endcase
        end
        in_yummy = yummy_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_noc_credit_rx.sv
// Bench for noc_credit_rx: directed vector table for the framing/credit corner cases,
// then credit-respecting random traffic against a queue-based reference model.
module tb_noc_credit_rx;

    localparam int DW        = 64;
    localparam int DEPTH     = 4;
    localparam int LEN_LSB   = 22;
    localparam int LEN_WIDTH = 8;
    localparam int NFLITS    = 10000;
    localparam int MAXCYC    = 40000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_yummy, out_valid, out_last, overflow;
    logic [DW-1:0] out_data;

    noc_credit_rx #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_LSB(LEN_LSB), .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_yummy(in_yummy), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: queued flits, flits left in the packet at the head, credit/overflow
    logic [DW-1:0] mq[$];
    int            pkt_left = 0;
    bit            m_yummy = 1'b0;
    bit            m_ovf = 1'b0;
    int            deq_total = 0;
    int            yummy_total = 0;

    typedef struct {
        bit            rst;
        bit            v;
        logic [DW-1:0] d;
        bit            rdy;
        bit            ev;
        bit            el;
        bit            ey;
        bit            eo;
    } vec_t;
    vec_t tbl[$];

    function automatic int len_of(logic [DW-1:0] d);
        return int'(d[LEN_LSB +: LEN_WIDTH]);
    endfunction

    function automatic logic [DW-1:0] mk(int len, logic [31:0] tag);
        logic [DW-1:0] r;
        r = {tag, 32'h0000_0000};
        r[LEN_LSB +: LEN_WIDTH] = LEN_WIDTH'(len);
        r[7:0] = tag[7:0];
        return r;
    endfunction

    function automatic bit model_last();
        if (mq.size() == 0) return 1'b0;
        if (pkt_left == 0) return (len_of(mq[0]) == 0);
        return (pkt_left == 1);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit v, input logic [DW-1:0] d, input bit rdy);
        bit deq, enq;
        reset = rst; in_valid = v; in_data = d; out_ready = rdy;
        deq = (mq.size() != 0) && rdy;
        enq = v && ((mq.size() < DEPTH) || deq);
        @(posedge clock);
        if (rst) begin
            mq.delete(); pkt_left = 0; m_yummy = 1'b0; m_ovf = 1'b0;
        end else begin
            if (deq) begin
                if (pkt_left == 0) pkt_left = len_of(mq[0]) + 1;
                pkt_left--;
                void'(mq.pop_front());
                deq_total++;
            end
            if (enq) mq.push_back(d);
            else if (v) m_ovf = 1'b1;
            m_yummy = deq;
        end
        @(negedge clock);
        if (in_yummy === 1'b1) yummy_total++;
        check("m_valid", DW'(out_valid), DW'(mq.size() != 0));
        if (mq.size() != 0) check("m_data", out_data, mq[0]);
        check("m_last", DW'(out_last), DW'(model_last()));
        check("m_yummy", DW'(in_yummy), DW'(m_yummy));
        check("m_overflow", DW'(overflow), DW'(m_ovf));
    endtask

    task automatic add(input bit rst, input bit v, input logic [DW-1:0] d, input bit rdy,
                       input bit ev, input bit el, input bit ey, input bit eo);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.rdy = rdy;
        t.ev = ev; t.el = el; t.ey = ey; t.eo = eo;
        tbl.push_back(t);
    endtask

    initial begin
        int credits, sent, pkt_rem, cyc, len;
        bit v, rdy;
        logic [DW-1:0] d;

        // reset, then single zero-length packet
        add(1, 0, '0, 1,                     0, 0, 0, 0);
        add(0, 1, mk(0, 32'hA0), 1,          1, 1, 0, 0);
        add(0, 0, '0, 1,                     0, 0, 1, 0);
        add(0, 0, '0, 1,                     0, 0, 0, 0);
        // length-3 packet streamed; body length fields must be ignored
        add(0, 1, mk(3, 32'hB0), 1,          1, 0, 0, 0);
        add(0, 1, mk(0, 32'hB1), 1,          1, 0, 1, 0);
        add(0, 1, mk(3, 32'hB2), 1,          1, 0, 1, 0);
        add(0, 1, mk(1, 32'hB3), 1,          1, 1, 1, 0);
        add(0, 0, '0, 1,                     0, 0, 1, 0);
        add(0, 0, '0, 1,                     0, 0, 0, 0);
        // fill with consumer stalled, fifth flit overflows, then drain
        add(0, 1, mk(0, 32'hC0), 0,          1, 1, 0, 0);
        add(0, 1, mk(0, 32'hC1), 0,          1, 1, 0, 0);
        add(0, 1, mk(0, 32'hC2), 0,          1, 1, 0, 0);
        add(0, 1, mk(0, 32'hC3), 0,          1, 1, 0, 0);
        add(0, 1, mk(0, 32'hC4), 0,          1, 1, 0, 1);
        add(0, 0, '0, 1,                     1, 1, 1, 1);
        add(0, 0, '0, 1,                     1, 1, 1, 1);
        add(0, 0, '0, 1,                     1, 1, 1, 1);
        add(0, 0, '0, 1,                     0, 0, 1, 1);
        add(0, 0, '0, 1,                     0, 0, 0, 1);
        // full FIFO with simultaneous enqueue/dequeue; occupancy stays at DEPTH
        add(1, 0, '0, 0,                     0, 0, 0, 0);
        add(0, 1, mk(0, 32'hD0), 0,          1, 1, 0, 0);
        add(0, 1, mk(0, 32'hD1), 0,          1, 1, 0, 0);
        add(0, 1, mk(0, 32'hD2), 0,          1, 1, 0, 0);
        add(0, 1, mk(0, 32'hD3), 0,          1, 1, 0, 0);
        add(0, 1, mk(0, 32'hD4), 1,          1, 1, 1, 0);
        add(0, 0, '0, 0,                     1, 1, 0, 0);
        add(0, 1, mk(0, 32'hD5), 0,          1, 1, 0, 1);
        // reset mid-packet; next flit is a header
        add(1, 0, '0, 1,                     0, 0, 0, 0);
        add(0, 1, mk(4, 32'hE0), 1,          1, 0, 0, 0);
        add(0, 1, mk(0, 32'hE1), 1,          1, 0, 1, 0);
        add(1, 1, mk(0, 32'hE2), 1,          0, 0, 0, 0);
        add(0, 1, mk(1, 32'hF0), 1,          1, 0, 0, 0);
        add(0, 1, mk(0, 32'hF1), 1,          1, 1, 1, 0);
        add(0, 0, '0, 1,                     0, 0, 1, 0);
        add(0, 0, '0, 1,                     0, 0, 0, 0);

        @(negedge clock);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].rdy);
            check($sformatf("v%0d_valid", i), DW'(out_valid), DW'(tbl[i].ev));
            check($sformatf("v%0d_last", i), DW'(out_last), DW'(tbl[i].el));
            check($sformatf("v%0d_yummy", i), DW'(in_yummy), DW'(tbl[i].ey));
            check($sformatf("v%0d_overflow", i), DW'(overflow), DW'(tbl[i].eo));
        end

        // random traffic from a sender that honours its DEPTH credits
        cycle(1, 0, '0, 1);
        deq_total = 0; yummy_total = 0;
        credits = DEPTH; sent = 0; pkt_rem = 0; cyc = 0;
        while (((sent < NFLITS) || (mq.size() != 0)) && (cyc < MAXCYC)) begin
            v = (sent < NFLITS) && (credits > 0) && ($urandom_range(0, 3) != 0);
            d = '0;
            if (v) begin
                if (pkt_rem == 0) begin
                    len = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 6));
                    d = mk(len, $urandom);
                    pkt_rem = len;
                end else begin
                    d = {$urandom, $urandom};
                    pkt_rem--;
                end
                credits--;
                sent++;
            end
            rdy = ($urandom_range(0, 9) < 7);
            cycle(1'b0, v, d, rdy);
            if (in_yummy === 1'b1) credits++;
            cyc++;
        end
        cycle(0, 0, '0, 1);
        if (in_yummy === 1'b1) credits++;
        check("rand_no_timeout", DW'(cyc < MAXCYC), DW'(1));
        check("rand_sent", DW'(sent), DW'(NFLITS));
        check("rand_yummy_total", DW'(yummy_total), DW'(deq_total));
        check("rand_credits_back", DW'(credits), DW'(DEPTH));
        check("rand_overflow", DW'(overflow), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
